// File: rtl/mmu_job_arbiter.sv
// Round-robin owner arbiter and job sequencer in front of one jollof_top MMU.
// Buffers each operand set, bursts it in, waits for finish, streams results back.
module mmu_job_arbiter #(
  parameter int NREQ      = 2,
  parameter int IN_BYTES  = 32,
  parameter int OUT_WORDS = 160,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_i,
  input  logic [3*NREQ-1:0]   req_nmat_i,
  output logic [NREQ-1:0]     gnt_o,
  input  logic [8*NREQ-1:0]   in_data_i,
  input  logic [NREQ-1:0]     in_valid_i,
  output logic [NREQ-1:0]     in_ready_o,
  output logic [17:0]         out_data_o,
  output logic [NREQ-1:0]     out_valid_o,
  output logic                out_last_o,
  output logic [NREQ-1:0]     done_o,
  output logic [NREQ-1:0]     err_o,
  output logic [7:0]          mmu_input_data_o,
  output logic                mmu_valid_input_o,
  output logic                mmu_read_ram_o,
  input  logic [17:0]         mmu_read_data_i,
  input  logic                mmu_finish_i
);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = $clog2(IN_BYTES);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, RSTART, READ} state_t;

  state_t          state_r, state_s;
  logic [RW-1:0]   owner_r, owner_s, rr_ptr_r, rr_ptr_s, pick_s;
  logic [2:0]      nmat_left_r, nmat_left_s, pick_nmat_s;
  logic [7:0]      cnt_r, cnt_s;
  logic [TW-1:0]   tmo_r, tmo_s;
  logic [NREQ-1:0] err_r, err_s, owner_oh_s;
  logic [7:0]      buf_mem [IN_BYTES];
  logic            pick_found_s, hs_s, wr_en_s, tmo_hit_s, emit_s;

  assign owner_oh_s = NREQ'(1) << owner_r;
  assign hs_s       = (state_r == LOAD) && in_valid_i[owner_r];
  assign tmo_hit_s  = (tmo_r == TW'(TIMEOUT - 1));

  // Round-robin scan starting one past the last owner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_s       = rr_ptr_r;
    for (int i = 1; i <= NREQ; i++) begin
      if (!pick_found_s && req_i[(int'(rr_ptr_r) + i) % NREQ]) begin
        pick_found_s = 1'b1;
        pick_s       = RW'((int'(rr_ptr_r) + i) % NREQ);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    pick_nmat_s = req_nmat_i[int'(pick_s)*3 +: 3];
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    nmat_left_s = nmat_left_r;
    cnt_s       = cnt_r;
    tmo_s       = tmo_r;
    err_s       = '0;
    wr_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s && (pick_nmat_s == 3'd0)) begin
          err_s[pick_s] = 1'b1;
        end else if (pick_found_s) begin
          owner_s     = pick_s;
          rr_ptr_s    = pick_s;
          nmat_left_s = pick_nmat_s;
          cnt_s       = 8'd0;
          tmo_s       = '0;
          state_s     = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (hs_s) begin
          wr_en_s = 1'b1;
          tmo_s   = '0;
          if (cnt_r == 8'(IN_BYTES - 1)) begin
            cnt_s   = 8'd0;
            state_s = FEED;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end else if (tmo_hit_s) begin
          err_s[owner_r] = 1'b1;
          state_s        = IDLE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      FEED: begin
        if (cnt_r == 8'(IN_BYTES - 1)) begin
          cnt_s   = 8'd0;
          tmo_s   = '0;
          state_s = WAIT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      WAIT: begin
        if (mmu_finish_i) begin
          cnt_s = 8'd0;
          tmo_s = '0;
          if (nmat_left_r > 3'd1) begin
            nmat_left_s = nmat_left_r - 3'd1;
            state_s     = LOAD;
          end else begin
            state_s = RSTART;
          end
        end else if (tmo_hit_s) begin
          err_s[owner_r] = 1'b1;
          state_s        = IDLE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      RSTART: begin
        // First non-zero word from the MMU marks the start of the result stream.
        if (mmu_read_data_i != 18'd0) begin
          cnt_s   = 8'd1;
          state_s = READ;
        end else if (tmo_hit_s) begin
          err_s[owner_r] = 1'b1;
          state_s        = IDLE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      READ: begin
        if (cnt_r == 8'(OUT_WORDS - 1)) begin
          cnt_s   = 8'd0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= RW'(NREQ - 1);
      nmat_left_r <= 3'd0;
      cnt_r       <= 8'd0;
      tmo_r       <= '0;
      err_r       <= '0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
      nmat_left_r <= nmat_left_s;
      cnt_r       <= cnt_s;
      tmo_r       <= tmo_s;
      err_r       <= err_s;
    end
  end

  // Operand buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_mem[cnt_r[IW-1:0]] <= in_data_i[int'(owner_r)*8 +: 8];
    end
  end

  assign emit_s = ((state_r == RSTART) && (mmu_read_data_i != 18'd0)) || (state_r == READ);

  // Output decode from the current state.
  always_comb begin
    gnt_o             = (state_r != IDLE) ? owner_oh_s : '0;
    in_ready_o        = (state_r == LOAD) ? owner_oh_s : '0;
    mmu_valid_input_o = (state_r == FEED);
    mmu_input_data_o  = (state_r == FEED) ? buf_mem[cnt_r[IW-1:0]] : 8'd0;
    mmu_read_ram_o    = (state_r == RSTART);
    out_valid_o       = emit_s ? owner_oh_s : '0;
    out_data_o        = emit_s ? mmu_read_data_i : 18'd0;
    out_last_o        = (state_r == READ) && (cnt_r == 8'(OUT_WORDS - 1));
    done_o            = out_last_o ? owner_oh_s : '0;
    err_o             = err_r;
  end
endmodule

// File: tb/tb_mmu_job_arbiter.sv
// Scoreboard bench for mmu_job_arbiter with a behavioural MMU and requester feeders.
module tb_mmu_job_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 16;

  logic              clk, rst;
  logic [NREQ-1:0]   req, gnt, in_valid, in_ready, out_valid, done, err;
  logic [3*NREQ-1:0] nmat;
  logic [8*NREQ-1:0] in_data;
  logic [17:0]       out_data, mmu_rd;
  logic              out_last, mmu_vin, mmu_rram, mmu_fin;
  logic [7:0]        mmu_din;

  mmu_job_arbiter #(.NREQ(NREQ), .IN_BYTES(32), .OUT_WORDS(160), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .req_nmat_i(nmat), .gnt_o(gnt),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last),
    .done_o(done), .err_o(err), .mmu_input_data_o(mmu_din),
    .mmu_valid_input_o(mmu_vin), .mmu_read_ram_o(mmu_rram),
    .mmu_read_data_i(mmu_rd), .mmu_finish_i(mmu_fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind: 0 grant, 1 fed byte, 2 result word, 3 error pulse
  typedef struct { int kind; int who; logic [17:0] data; int gap; logic last; } ev_t;
  ev_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, last_done_cyc = -100, last_feed_cyc = -100;
  bit no_finish = 1'b0;
  bit gapped [NREQ];
  int fcnt [NREQ];

  function automatic int base_of(int r);
    return r * 128;
  endfunction

  function automatic logic [17:0] word_of(int r, int k);
    return 18'h10000 + 18'(r) * 18'h01000 + 18'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_job(input int r, input int nsets, input int ggap);
    q.push_back('{kind: 0, who: r, data: 18'd0, gap: ggap, last: 1'b0});
    for (int s = 0; s < nsets; s++)
      for (int i = 0; i < 32; i++)
        q.push_back('{kind: 1, who: r, data: 18'((base_of(r) + s * 32 + i) % 256), gap: 0, last: 1'b0});
    for (int k = 0; k < 160; k++)
      q.push_back('{kind: 2, who: r, data: word_of(r, k), gap: 0, last: (k == 159)});
  endtask

  // Requester feeders: one byte per handshake, optional every-other-cycle valid.
  initial begin
    bit hs [NREQ];
    bit phase = 1'b0;
    logic [NREQ-1:0] pg = '0;
    in_valid = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) hs[r] = in_valid[r] && in_ready[r] && !rst;
      @(posedge clk);
      #1;
      phase = ~phase;
      for (int r = 0; r < NREQ; r++) begin
        if (gnt[r] && !pg[r]) fcnt[r] = 0;
        else if (hs[r]) fcnt[r]++;
        in_valid[r]      = gapped[r] ? phase : 1'b1;
        in_data[r*8 +: 8] = 8'((base_of(r) + fcnt[r]) % 256);
      end
      pg = gnt;
    end
  end

  // Behavioural MMU: finish 3 cycles after each 32-byte burst, results after read_ram.
  initial begin
    int feed_n = 0, fin_wait = 0, zero_n = 0, k = 0, rd_owner = 0;
    bit reading = 1'b0, rs;
    mmu_fin = 1'b0;
    mmu_rd  = 18'd0;
    forever begin
      @(posedge clk);
      rs = rst;
      #1;
      mmu_fin = 1'b0;
      if (rs) begin
        feed_n = 0; fin_wait = 0; reading = 1'b0; mmu_rd = 18'd0;
      end else begin
        if (mmu_vin) begin
          feed_n++;
          if (feed_n == 32) begin feed_n = 0; fin_wait = 3; end
        end
        if (fin_wait > 0) begin
          fin_wait--;
          if (fin_wait == 0 && !no_finish) mmu_fin = 1'b1;
        end
        if (mmu_rram && !reading) begin
          reading = 1'b1; zero_n = 2; k = 0;
          rd_owner = gnt[1] ? 1 : 0;
        end
        if (reading) begin
          if (zero_n > 0) begin zero_n--; mmu_rd = 18'd0; end
          else if (k < 160) begin mmu_rd = word_of(rd_owner, k); k++; end
          else begin mmu_rd = 18'd0; reading = 1'b0; end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an observable event.
  initial begin
    logic [NREQ-1:0] prev_gnt = '0;
    bit post_done = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (post_done) begin chk("gnt_after_done", 32'(gnt), 32'd0); post_done = 1'b0; end
      if (err != '0) begin
        if (q.size() == 0) begin failures++; checks++; $display("FAIL unexpected_err actual=%0h required=none", err); end
        else begin
          e = q.pop_front();
          chk("err_kind", 32'd3, 32'(e.kind));
          chk("err_who", 32'(err), 32'(1 << e.who));
          chk("err_gnt_clear", 32'(gnt), 32'd0);
          if (e.gap > 0) chk("timeout_latency", 32'(cyc - last_feed_cyc), 32'(e.gap));
        end
      end
      if (gnt != '0 && gnt != prev_gnt) begin
        if (q.size() == 0) begin failures++; checks++; $display("FAIL unexpected_gnt actual=%0h required=none", gnt); end
        else begin
          e = q.pop_front();
          chk("gnt_kind", 32'd0, 32'(e.kind));
          chk("gnt_who", 32'(gnt), 32'(1 << e.who));
          chk("gnt_ready", 32'(in_ready), 32'(gnt));
          if (e.gap > 0) chk("grant_gap", 32'(cyc - last_done_cyc), 32'(e.gap));
        end
      end
      if (mmu_vin) begin
        last_feed_cyc = cyc;
        if (q.size() == 0) begin failures++; checks++; $display("FAIL unexpected_byte actual=%0h required=none", mmu_din); end
        else begin
          e = q.pop_front();
          chk("byte_kind", 32'd1, 32'(e.kind));
          chk("feed_byte", 32'(mmu_din), 32'(e.data));
        end
      end
      if (out_valid != '0) begin
        if (q.size() == 0) begin failures++; checks++; $display("FAIL unexpected_word actual=%0h required=none", out_data); end
        else begin
          e = q.pop_front();
          chk("word_kind", 32'd2, 32'(e.kind));
          chk("word_owner", 32'(out_valid), 32'(1 << e.who));
          chk("word_data", 32'(out_data), 32'(e.data));
          chk("word_last", 32'(out_last), 32'(e.last));
          chk("word_done", 32'(done), e.last ? 32'(1 << e.who) : 32'd0);
        end
        if (out_last) begin last_done_cyc = cyc; post_done = 1'b1; end
      end else if (done != '0 || out_last) begin
        chk("done_without_word", 32'({done, out_last}), 32'd0);
      end
      prev_gnt = gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_outv"}, 32'({out_valid, out_last, done, err}), 32'd0);
    chk({nm, "_mmu"}, 32'({mmu_vin, mmu_rram, mmu_din}), 32'd0);
    chk({nm, "_data"}, 32'(out_data), 32'd0);
  endtask

  task automatic wait_gnt(input int r);
    int n = 0;
    while (!gnt[r] && n < 3000) begin step(); n++; end
    chk("wait_gnt", 32'(gnt[r]), 32'd1);
  endtask

  task automatic wait_err(input int r);
    int n = 0;
    while (!err[r] && n < 3000) begin step(); n++; end
    chk("wait_err", 32'(err[r]), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || gnt != '0) && n < 3000) begin step(); n++; end
    step(); step();
    chk("drain_queue", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; nmat = '0;
    gapped[0] = 1'b0; gapped[1] = 1'b0;
    step();
    do_reset();

    // Single job from requester 0
    push_job(0, 1, 0);
    nmat = {3'd0, 3'd1}; req = 2'b01;
    wait_gnt(0); req = 2'b00;
    drain();

    // Round robin 0,1,0 with both requests held
    do_reset();
    push_job(0, 1, 0); push_job(1, 1, 2); push_job(0, 1, 2);
    nmat = {3'd1, 3'd1}; req = 2'b11;
    wait_gnt(0);
    wait_gnt(1); req[1] = 1'b0;
    wait_gnt(0); req[0] = 1'b0;
    drain();

    // Reject of a zero-set request, then requester 0 served
    q.push_back('{kind: 3, who: 1, data: 18'd0, gap: 0, last: 1'b0});
    push_job(0, 1, 0);
    nmat = {3'd0, 3'd1}; req = 2'b11;
    wait_err(1); req[1] = 1'b0;
    wait_gnt(0); req[0] = 1'b0;
    drain();

    // Three sets with gapped operand bytes
    gapped[1] = 1'b1;
    push_job(1, 3, 0);
    nmat = {3'd3, 3'd0}; req = 2'b10;
    wait_gnt(1); req = 2'b00;
    drain();
    gapped[1] = 1'b0;

    // Timeout in WAIT with no finish from the MMU
    no_finish = 1'b1;
    q.push_back('{kind: 0, who: 0, data: 18'd0, gap: 0, last: 1'b0});
    for (int i = 0; i < 32; i++) q.push_back('{kind: 1, who: 0, data: 18'(i), gap: 0, last: 1'b0});
    q.push_back('{kind: 3, who: 0, data: 18'd0, gap: TMO + 1, last: 1'b0});
    nmat = {3'd0, 3'd1}; req = 2'b01;
    wait_gnt(0); req = 2'b00;
    drain();
    no_finish = 1'b0;

    // Reset during the burst at byte 10, then a fresh arbitration from requester 0
    q.push_back('{kind: 0, who: 0, data: 18'd0, gap: 0, last: 1'b0});
    for (int i = 0; i <= 10; i++) q.push_back('{kind: 1, who: 0, data: 18'(i), gap: 0, last: 1'b0});
    req = 2'b01;
    wait_gnt(0); req = 2'b00;
    begin
      int n = 0;
      while (!(mmu_vin && mmu_din == 8'd10) && n < 500) begin step(); n++; end
      chk("reach_byte10", 32'({mmu_vin, mmu_din}), 32'h10a);
    end
    rst = 1'b1;
    step();
    chk_idle_outputs("midfeed_reset");
    rst = 1'b0;
    push_job(0, 1, 0);
    nmat = {3'd1, 3'd1}; req = 2'b11;
    wait_gnt(0); req = 2'b00;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
